regfile_write_arbiter: RTL and testbench

Controller in front of the 64-bit, 32-entry register file's single write port. After reset it sweeps every register to zero. It then arbitrates round-robin between two writeback requesters: A (ALU result) and B (load data from data memory). It drives `WriteSelect`/`WriteData`/`WriteEnable` into `Register_File`, suppresses writes to XZR (X31), and flags read-after-write hazards for the decode-stage read selects.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_write_arbiter_rr_arb2.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 95 +++++++++
 tb/tb_regfile_write_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and state encoding for the register-file write arbiter
package regfile_pkg;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 5;
    localparam int NREGS   = 32;
    localparam int XZR_IDX = 31;

    typedef enum logic {
        S_INIT = 1'b0,
        S_ARB  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// rtl/regfile_write_arbiter_rr_arb2.sv - two-requester round-robin arbiter with priority pointer
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic aValid,
    input  logic bValid,
    output logic aReady,
    output logic bReady,
    output logic aAccept,
    output logic bAccept
);

    // ptrB low: A wins a tie; high: B wins a tie
    logic ptrB;
    logic contend;

    assign contend = aValid & bValid;
    assign aReady  = enable & ~(contend & ptrB);
    assign bReady  = enable & ~(contend & ~ptrB);
    assign aAccept = aValid & aReady;
    assign bAccept = bValid & bReady;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptrB <= 1'b0;
        end else if (aAccept) begin
            ptrB <= 1'b1;
        end else if (bAccept) begin
            ptrB <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - zero sweep, round-robin writeback arbitration and hazard flags for the register file
module regfile_write_arbiter
    import regfile_pkg::state_t;
    import regfile_pkg::S_INIT;
    import regfile_pkg::S_ARB;
#(
    parameter int DATA_W     = regfile_pkg::DATA_W,
    parameter int ADDR_W     = regfile_pkg::ADDR_W,
    parameter int NREGS      = regfile_pkg::NREGS,
    parameter int XZR_IDX    = regfile_pkg::XZR_IDX,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_sel,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_sel,
    input  logic [DATA_W-1:0] b_data,
    input  logic [ADDR_W-1:0] ReadSelect1,
    input  logic [ADDR_W-1:0] ReadSelect2,
    output logic [ADDR_W-1:0] WriteSelect,
    output logic [DATA_W-1:0] WriteData,
    output logic              WriteEnable,
    output logic              hazard1,
    output logic              hazard2,
    output logic              init_done
);

    localparam int CNT_W = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_IDX);

    state_t           state;
    logic [CNT_W-1:0] sweepCnt;
    logic             aAccept;
    logic             bAccept;

    // Readies wait for init_done so the final sweep write (X31) is never overwritten
    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .enable  (init_done),
        .aValid  (a_valid),
        .bValid  (b_valid),
        .aReady  (a_ready),
        .bReady  (b_ready),
        .aAccept (aAccept),
        .bAccept (bAccept)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= INIT_CLEAR ? S_INIT : S_ARB;
            sweepCnt    <= '0;
            WriteEnable <= 1'b0;
            WriteSelect <= '0;
            WriteData   <= '0;
            init_done   <= 1'b0;
        end else begin
            init_done <= (state == S_ARB);
            case (state)
                S_INIT: begin
                    WriteEnable <= 1'b1;
                    WriteSelect <= ADDR_W'(sweepCnt);
                    WriteData   <= '0;
                    if (sweepCnt == CNT_W'(NREGS - 1)) begin
                        state <= S_ARB;
                    end else begin
                        sweepCnt <= sweepCnt + 1'b1;
                    end
                end
                default: begin
                    if (aAccept) begin
                        WriteSelect <= a_sel;
                        WriteData   <= a_data;
                        WriteEnable <= (a_sel != XZR);
                    end else if (bAccept) begin
                        WriteSelect <= b_sel;
                        WriteData   <= b_data;
                        WriteEnable <= (b_sel != XZR);
                    end else begin
                        WriteEnable <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign hazard1 = (state == S_ARB) & WriteEnable & (WriteSelect == ReadSelect1) & (ReadSelect1 != XZR);
    assign hazard2 = (state == S_ARB) & WriteEnable & (WriteSelect == ReadSelect2) & (ReadSelect2 != XZR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_sel, b_sel;
    logic [63:0] a_data, b_data;
    logic [4:0]  ReadSelect1, ReadSelect2;
    logic [4:0]  WriteSelect;
    logic [63:0] WriteData;
    logic        WriteEnable;
    logic        hazard1, hazard2;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_sel       (a_sel),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_sel       (b_sel),
        .b_data      (b_data),
        .ReadSelect1 (ReadSelect1),
        .ReadSelect2 (ReadSelect2),
        .WriteSelect (WriteSelect),
        .WriteData   (WriteData),
        .WriteEnable (WriteEnable),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .init_done   (init_done)
    );

    task automatic test_reset();
        rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        a_sel = 5'd0; b_sel = 5'd0; a_data = '0; b_data = '0;
        ReadSelect1 = 5'd0; ReadSelect2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({WriteEnable, WriteSelect, WriteData, init_done} !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%0b sel=%0d data=%0h done=%0b, required all 0",
                     WriteEnable, WriteSelect, WriteData, init_done);
        end
        checks++;
        if ({a_ready, b_ready, hazard1, hazard2} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready_hazard: got %b, required 0000", {a_ready, b_ready, hazard1, hazard2});
        end
    endtask

    task automatic test_sweep();
        rst = 1'b1;
        ReadSelect1 = 5'd7;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (WriteEnable !== 1'b1 || WriteSelect !== 5'(k) || WriteData !== 64'd0) begin
                errors++;
                $display("FAIL sweep_write k=%0d: we=%0b sel=%0d data=%0h, required 1/%0d/0",
                         k, WriteEnable, WriteSelect, WriteData, k);
            end
            checks++;
            if ({a_ready, b_ready, init_done, hazard1} !== 4'b0000) begin
                errors++;
                $display("FAIL sweep_idle k=%0d: ready/done/hazard1=%b, required 0000",
                         k, {a_ready, b_ready, init_done, hazard1});
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (init_done !== 1'b1 || WriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done: done=%0b we=%0b, required done=1 we=0", init_done, WriteEnable);
        end
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_sel = 5'd5; a_data = 64'h1; b_valid = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: a=%0b b=%0b, required 1 1", a_ready, b_ready);
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        checks++;
        if (WriteEnable !== 1'b1 || WriteSelect !== 5'd5 || WriteData !== 64'h1) begin
            errors++;
            $display("FAIL single_write: we=%0b sel=%0d data=%0h, required 1/5/1", WriteEnable, WriteSelect, WriteData);
        end
        @(posedge clk);
        #1;
        checks++;
        if (WriteEnable !== 1'b0 || WriteSelect !== 5'd5 || WriteData !== 64'h1) begin
            errors++;
            $display("FAIL single_idle_hold: we=%0b sel=%0d data=%0h, required 0/5/1", WriteEnable, WriteSelect, WriteData);
        end
    endtask

    task automatic test_xzr();
        b_valid = 1'b1; b_sel = 5'd31; b_data = 64'hFFFF; ReadSelect1 = 5'd31;
        #1;
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL xzr_ready: b_ready=%0b, required 1", b_ready);
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        checks++;
        if (WriteEnable !== 1'b0 || WriteSelect !== 5'd31 || WriteData !== 64'hFFFF || hazard1 !== 1'b0) begin
            errors++;
            $display("FAIL xzr_suppress: we=%0b sel=%0d data=%0h hz1=%0b, required 0/31/ffff/0",
                     WriteEnable, WriteSelect, WriteData, hazard1);
        end
    endtask

    task automatic test_contention();
        a_valid = 1'b1; a_sel = 5'd1; a_data = 64'hA;
        b_valid = 1'b1; b_sel = 5'd2; b_data = 64'hB;
        ReadSelect1 = 5'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (a_ready !== ((i % 2) == 0) || b_ready !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL contend_ready i=%0d: a=%0b b=%0b, required a=%0b b=%0b",
                         i, a_ready, b_ready, (i % 2) == 0, (i % 2) == 1);
            end
            @(posedge clk);
            #1;
            checks++;
            if (WriteEnable !== 1'b1 || WriteSelect !== ((i % 2) == 0 ? 5'd1 : 5'd2) ||
                WriteData !== ((i % 2) == 0 ? 64'hA : 64'hB)) begin
                errors++;
                $display("FAIL contend_write i=%0d: we=%0b sel=%0d data=%0h", i, WriteEnable, WriteSelect, WriteData);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (WriteEnable !== 1'b0 || WriteSelect !== 5'd2) begin
            errors++;
            $display("FAIL contend_drop: we=%0b sel=%0d, required 0/2", WriteEnable, WriteSelect);
        end
    endtask

    task automatic test_hazard();
        ReadSelect1 = 5'd0; ReadSelect2 = 5'd0;
        a_valid = 1'b1; a_sel = 5'd3; a_data = 64'h33;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        ReadSelect2 = 5'd3;
        #1;
        checks++;
        if (WriteEnable !== 1'b1 || hazard2 !== 1'b1 || hazard1 !== 1'b0) begin
            errors++;
            $display("FAIL hazard_raise: we=%0b hz1=%0b hz2=%0b, required 1/0/1", WriteEnable, hazard1, hazard2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (hazard2 !== 1'b0) begin
            errors++;
            $display("FAIL hazard_clear: hz2=%0b, required 0", hazard2);
        end
    endtask

    task automatic test_reset_mid_sweep();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (WriteSelect !== 5'd10 || WriteEnable !== 1'b1) begin
            errors++;
            $display("FAIL midsweep_reach: sel=%0d we=%0b, required 10/1", WriteSelect, WriteEnable);
        end
        rst = 1'b0;
        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({WriteEnable, WriteSelect, WriteData, init_done} !== 71'd0) begin
                errors++;
                $display("FAIL midsweep_reset e=%0d: we=%0b sel=%0d data=%0h done=%0b, required all 0",
                         e, WriteEnable, WriteSelect, WriteData, init_done);
            end
        end
        rst = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; ReadSelect1 = 5'd5;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (WriteEnable !== 1'b1 || WriteSelect !== 5'(k) || hazard1 !== 1'b0 || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL resweep k=%0d: we=%0b sel=%0d hz1=%0b a_ready=%0b, required 1/%0d/0/0",
                         k, WriteEnable, WriteSelect, hazard1, a_ready, k);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL resweep_done: done=%0b, required 1", init_done);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_single();
        test_xzr();
        test_contention();
        test_hazard();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
